bus_ctrl_unit: RTL and testbench

Initiator side of the shared 3-bit register bus. Accepts one instruction at a time over a valid/ready handshake and sequences the per-register R_in/R_out strobes, accumulator/ALU strobes and its own immediate-drive onto the tri-state bus. Sits between the instruction source and the register file/ALU. It is the only block that decides who drives and who samples the bus in each cycle.

---
 rtl/bus_ctrl_pkg.sv | 22 ++
 rtl/bus_ctrl_unit_reg_sel_decoder.sv | 22 ++
 rtl/bus_ctrl_unit.sv | 207 ++++++++++++++++++++
 tb/tb_bus_ctrl_unit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared definitions for the register-bus controller.
//   - DW_DEFAULT / NREG_DEFAULT : default bus width and register count
//   - OP_*                      : 2-bit opcode encodings
//   - state_t                   : controller FSM state encoding
package bus_ctrl_pkg;

  localparam int DW_DEFAULT   = 3;
  localparam int NREG_DEFAULT = 4;

  localparam logic [1:0] OP_MVI = 2'b00;
  localparam logic [1:0] OP_MV  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_ctrl_unit_reg_sel_decoder.sv
// reg_sel_decoder: register index -> one-hot select vector.
// Ports:
//   en     in  1   when low the whole vector is 0
//   idx    in  IW  register index
//   onehot out N   bit idx set when en=1, else all 0
module reg_sel_decoder #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/bus_ctrl_unit.sv
// bus_ctrl_unit: initiator side of the shared register bus.
// Takes one instruction (MVI/MV/ADD/SUB) at a time and sequences the
// register load/output strobes, accumulator/ALU strobes and its own
// immediate drive onto the tri-state bus.
//
// Handshake: an instruction is accepted on a rising edge where
// instr_valid and instr_ready are both 1. instr_ready is high only in
// IDLE; fields are ignored on any edge without acceptance.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid/ready   instruction handshake
//   instr_op/rx/ry/imm  opcode, register indices, immediate
//   bus                 shared tri-state data bus (driven only when ext_out)
//   ext_out             controller drives bus with the latched immediate
//   R_in, R_out         one-hot register load / output-enable strobes
//   A_in, G_in, G_out   accumulator load, ALU result load / drive
//   alu_sub             ALU subtract select
//   done                one-cycle pulse in the final transfer cycle
//   err                 sticky bus-conflict flag
//   dbg_state           current FSM state, for observation
//
// Build option: define BUS_CONFLICT_CHECK_EN to enable the bus-driver
// conflict checker; otherwise err is tied 0.
import bus_ctrl_pkg::*;

module bus_ctrl_unit #(
  parameter int NREG = NREG_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  localparam int IW  = (NREG <= 2) ? 1 : $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      instr_op,
  input  logic [IW-1:0]   instr_rx,
  input  logic [IW-1:0]   instr_ry,
  input  logic [DW-1:0]   instr_imm,
  inout  wire  [DW-1:0]   bus,
  output logic            ext_out,
  output logic [NREG-1:0] R_in,
  output logic [NREG-1:0] R_out,
  output logic            A_in,
  output logic            G_in,
  output logic            G_out,
  output logic            alu_sub,
  output logic            done,
  output logic            err,
  output logic [1:0]      dbg_state
);

  state_t          state;
  logic [1:0]      op_q;
  logic [IW-1:0]   rx_q;
  logic [IW-1:0]   ry_q;
  logic [DW-1:0]   imm_q;

  // Register selects are held as enable + index and expanded by the
  // decoders, so R_in/R_out are one-hot by construction.
  logic            rin_en;
  logic [IW-1:0]   rin_sel;
  logic            rout_en;
  logic [IW-1:0]   rout_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_ready <= 1'b0;
      op_q        <= OP_MVI;
      rx_q        <= '0;
      ry_q        <= '0;
      imm_q       <= '0;
      rin_en      <= 1'b0;
      rin_sel     <= '0;
      rout_en     <= 1'b0;
      rout_sel    <= '0;
      ext_out     <= 1'b0;
      A_in        <= 1'b0;
      G_in        <= 1'b0;
      G_out       <= 1'b0;
      alu_sub     <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless the next state asserts them.
      rin_en  <= 1'b0;
      rout_en <= 1'b0;
      ext_out <= 1'b0;
      A_in    <= 1'b0;
      G_in    <= 1'b0;
      G_out   <= 1'b0;
      alu_sub <= 1'b0;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q        <= instr_op;
            rx_q        <= instr_rx;
            ry_q        <= instr_ry;
            imm_q       <= instr_imm;
            instr_ready <= 1'b0;
            state       <= S_T1;
            // T1 strobes come straight from the fields being latched.
            case (instr_op)
              OP_MVI: begin
                ext_out <= 1'b1;
                rin_en  <= 1'b1;
                rin_sel <= instr_rx;
                done    <= 1'b1;
              end
              OP_MV: begin
                rout_en  <= 1'b1;
                rout_sel <= instr_ry;
                rin_en   <= 1'b1;
                rin_sel  <= instr_rx;
                done     <= 1'b1;
              end
              default: begin
                rout_en  <= 1'b1;
                rout_sel <= instr_rx;
                A_in     <= 1'b1;
              end
            endcase
          end else begin
            instr_ready <= 1'b1;
          end
        end

        S_T1: begin
          if (op_q == OP_MVI || op_q == OP_MV) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
          end else begin
            state    <= S_T2;
            rout_en  <= 1'b1;
            rout_sel <= ry_q;
            G_in     <= 1'b1;
            alu_sub  <= (op_q == OP_SUB);
          end
        end

        S_T2: begin
          state   <= S_T3;
          G_out   <= 1'b1;
          rin_en  <= 1'b1;
          rin_sel <= rx_q;
          done    <= 1'b1;
        end

        S_T3: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
        end

        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

  reg_sel_decoder #(.N(NREG), .IW(IW)) u_rin_dec (
    .en     (rin_en),
    .idx    (rin_sel),
    .onehot (R_in)
  );

  reg_sel_decoder #(.N(NREG), .IW(IW)) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_sel),
    .onehot (R_out)
  );

  assign bus = ext_out ? imm_q : {DW{1'bz}};

`ifdef BUS_CONFLICT_CHECK_EN
  // Counts every bus driver independently so that a decoder producing
  // more than one R_out bit is caught as well.
  logic [IW+1:0] drv_cnt;

  always_comb begin
    drv_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      drv_cnt = drv_cnt + (IW+2)'(R_out[i]);
    end
    drv_cnt = drv_cnt + (IW+2)'(G_out) + (IW+2)'(ext_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (drv_cnt > (IW+2)'(1)) begin
      err <= 1'b1;
`ifndef SYNTHESIS
      $error("bus_ctrl_unit: %0d simultaneous bus drivers", drv_cnt);
`endif
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_ctrl_unit.sv
// tb_bus_ctrl_unit: self-checking bench for bus_ctrl_unit.
// Contains a behavioural register file, accumulator and ALU hanging off
// the bus, a golden register model, and a per-cycle strobe scoreboard.
module tb_bus_ctrl_unit;
  import bus_ctrl_pkg::*;

  localparam int NREG = 4;
  localparam int DW   = 3;
  localparam int IW   = 2;
  localparam int W    = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [1:0]      instr_op  = 2'b00;
  logic [IW-1:0]   instr_rx  = '0;
  logic [IW-1:0]   instr_ry  = '0;
  logic [DW-1:0]   instr_imm = '0;
  wire  [DW-1:0]   bus;
  logic            ext_out;
  logic [NREG-1:0] R_in;
  logic [NREG-1:0] R_out;
  logic            A_in, G_in, G_out, alu_sub, done, err;
  logic [1:0]      dbg_state;

  bus_ctrl_unit #(.NREG(NREG), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rx    (instr_rx),
    .instr_ry    (instr_ry),
    .instr_imm   (instr_imm),
    .bus         (bus),
    .ext_out     (ext_out),
    .R_in        (R_in),
    .R_out       (R_out),
    .A_in        (A_in),
    .G_in        (G_in),
    .G_out       (G_out),
    .alu_sub     (alu_sub),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- bus environment: register file, A, ALU/G ----------------
  logic          env_clr = 1'b1;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] acc;
  logic [DW-1:0] g_reg;
  logic          env_en;
  logic [DW-1:0] env_val;

  always_comb begin
    env_en  = 1'b0;
    env_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (R_out[i]) begin
        env_en  = 1'b1;
        env_val = regs[i];
      end
    end
    if (G_out) begin
      env_en  = 1'b1;
      env_val = g_reg;
    end
  end

  assign bus = env_en ? env_val : {DW{1'bz}};

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      acc   <= '0;
      g_reg <= '0;
    end else begin
      if (A_in) acc <= bus;
      if (G_in) g_reg <= alu_sub ? (acc - bus) : (acc + bus);
      for (int i = 0; i < NREG; i++) begin
        if (R_in[i]) regs[i] <= bus;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [DW:0]   exp_bus_q[$];   // {check, value}
  logic [DW-1:0] gold [NREG];
  int n_tests = 0;
  int n_fail  = 0;

  wire [W-1:0] obs = {instr_ready, ext_out, R_in, R_out, A_in, G_in, G_out, alu_sub, done};

  function automatic logic [W-1:0] pk(input logic rdy, input logic ext,
                                      input logic [3:0] rin, input logic [3:0] rout,
                                      input logic a, input logic g, input logic go,
                                      input logic sub, input logic dn);
    return {rdy, ext, rin, rout, a, g, go, sub, dn};
  endfunction

  function automatic logic [3:0] oh(input logic [IW-1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

  always @(negedge clk) begin : monitor
    logic [W-1:0]  e;
    logic [DW:0]   eb;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eb = exp_bus_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL strobes: got rdy/ext/rin/rout/a/g/go/sub/dn=%b required %b", obs, e);
      end
      if (eb[DW]) begin
        n_tests++;
        if (bus !== eb[DW-1:0]) begin
          n_fail++;
          $display("FAIL bus_value: got %b required %b", bus, eb[DW-1:0]);
        end
      end
    end
  end

  // Expected per-cycle strobes after an accept edge; also updates the
  // golden register model.
  task automatic push_seq(input logic [1:0] op, input logic [IW-1:0] rx,
                          input logic [IW-1:0] ry, input logic [DW-1:0] imm);
    logic [DW-1:0] a, b, res;
    logic          sub;
    a   = gold[rx];
    b   = gold[ry];
    sub = (op == OP_SUB);
    res = sub ? (a - b) : (a + b);
    case (op)
      OP_MVI: begin
        exp_q.push_back(pk(1'b0, 1'b1, oh(rx), 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_bus_q.push_back({1'b1, imm});
        gold[rx] = imm;
      end
      OP_MV: begin
        exp_q.push_back(pk(1'b0, 1'b0, oh(rx), oh(ry), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_bus_q.push_back({1'b1, b});
        gold[rx] = b;
      end
      default: begin
        exp_q.push_back(pk(1'b0, 1'b0, 4'b0, oh(rx), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_bus_q.push_back({1'b1, a});
        exp_q.push_back(pk(1'b0, 1'b0, 4'b0, oh(ry), 1'b0, 1'b1, 1'b0, sub, 1'b0));
        exp_bus_q.push_back({1'b1, b});
        exp_q.push_back(pk(1'b0, 1'b0, oh(rx), 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        exp_bus_q.push_back({1'b1, res});
        gold[rx] = res;
      end
    endcase
    // Cycle after done: back in IDLE, ready again, nothing driving.
    exp_q.push_back(pk(1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_bus_q.push_back('0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [IW-1:0] rx,
                      input logic [IW-1:0] ry, input logic [DW-1:0] imm);
    @(negedge clk);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_accept: got %b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rx    = rx;
    instr_ry    = ry;
    instr_imm   = imm;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    push_seq(op, rx, ry, imm);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected cycles left, required 0", exp_q.size());
      exp_q.delete();
      exp_bus_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    env_clr = 1'b0;
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 1", instr_ready);
    end
    // Two reset cycles while idle.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== '0 || ext_out !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_reset_cycle%0d: got %b required 0", c, obs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== pk(1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL idle_reset_release: got %b required ready only", obs);
    end
  endtask

  task automatic test_mvi();
    send(OP_MVI, 2'd1, 2'd0, 3'b101);
    drain();
    n_tests++;
    if (regs[1] !== 3'b101) begin
      n_fail++;
      $display("FAIL mvi_r1: got %b required 101", regs[1]);
    end
  endtask

  task automatic test_mv();
    send(OP_MV, 2'd2, 2'd1, 3'b000);
    drain();
    n_tests++;
    if (regs[2] !== 3'b101) begin
      n_fail++;
      $display("FAIL mv_r2: got %b required 101", regs[2]);
    end
    send(OP_MV, 2'd2, 2'd2, 3'b000);
    drain();
    n_tests++;
    if (regs[2] !== 3'b101) begin
      n_fail++;
      $display("FAIL mv_self: got %b required 101", regs[2]);
    end
  endtask

  task automatic test_alu();
    send(OP_MVI, 2'd2, 2'd0, 3'b110);
    drain();
    send(OP_ADD, 2'd1, 2'd2, 3'b000);
    drain();
    n_tests++;
    if (regs[1] !== 3'b011) begin
      n_fail++;
      $display("FAIL add_wrap_r1: got %b required 011", regs[1]);
    end
    send(OP_MVI, 2'd3, 2'd0, 3'b100);
    drain();
    send(OP_SUB, 2'd3, 2'd3, 3'b000);
    drain();
    n_tests++;
    if (regs[3] !== 3'b000) begin
      n_fail++;
      $display("FAIL sub_self_r3: got %b required 000", regs[3]);
    end
    send(OP_MVI, 2'd0, 2'd0, 3'b011);
    drain();
    send(OP_ADD, 2'd0, 2'd0, 3'b000);
    drain();
    n_tests++;
    if (regs[0] !== 3'b110) begin
      n_fail++;
      $display("FAIL add_double_r0: got %b required 110", regs[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [DW-1:0] r1_before;
    r1_before = gold[1];
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = OP_ADD;
    instr_rx    = 2'd1;
    instr_ry    = 2'd2;
    instr_imm   = 3'b000;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    exp_q.push_back(pk(1'b0, 1'b0, 4'b0, oh(2'd1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_bus_q.push_back({1'b1, gold[1]});
    exp_q.push_back(pk(1'b0, 1'b0, 4'b0, oh(2'd2), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_bus_q.push_back({1'b1, gold[2]});
    @(negedge clk);   // T1
    @(negedge clk);   // T2
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_in_t2: got %b required 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== pk(1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL after_abort_idle: got %b required ready only", obs);
    end
    n_tests++;
    if (regs[1] !== r1_before) begin
      n_fail++;
      $display("FAIL abort_r1_unchanged: got %b required %b", regs[1], r1_before);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr_op    = OP_MVI;
    instr_rx    = 2'd0;
    instr_ry    = 2'd0;
    instr_imm   = 3'b111;
    @(posedge clk);
    #1;
    push_seq(OP_MVI, 2'd0, 2'd0, 3'b111);
    @(negedge clk);   // T1 of MVI: offer the next one while busy
    instr_op  = OP_MV;
    instr_rx  = 2'd3;
    instr_ry  = 2'd0;
    instr_imm = 3'b010;
    @(posedge clk);   // not accepted, back to IDLE
    @(posedge clk);   // accepted
    #1;
    instr_valid = 1'b0;
    push_seq(OP_MV, 2'd3, 2'd0, 3'b010);
    drain();
    n_tests++;
    if (regs[3] !== 3'b111) begin
      n_fail++;
      $display("FAIL b2b_r3: got %b required 111", regs[3]);
    end
  endtask

  task automatic test_random();
    logic [1:0]    op;
    logic [IW-1:0] rx, ry;
    logic [DW-1:0] imm;
    for (int i = 0; i < 16; i++) begin
      op  = 2'($urandom_range(0, 3));
      rx  = IW'($urandom_range(0, NREG-1));
      ry  = IW'($urandom_range(0, NREG-1));
      imm = DW'($urandom_range(0, 7));
      send(op, rx, ry, imm);
      drain();
      n_tests++;
      if (regs[rx] !== gold[rx]) begin
        n_fail++;
        $display("FAIL random_%0d op%0d r%0d: got %b required %b", i, op, rx, regs[rx], gold[rx]);
      end
    end
  endtask

  task automatic test_err();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_quiet: got %b required 0", err);
    end
`ifdef BUS_CONFLICT_CHECK_EN
    @(negedge clk);
    force dut.R_out = 4'b0011;
    @(negedge clk);
    release dut.R_out;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b required 1", err);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b required 1", err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got %b required 0", err);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) gold[i] = '0;
    test_reset();
    test_mvi();
    test_mv();
    test_alu();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    test_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
